pll_lock_monitor: RTL and testbench
===================================

Name: pll_lock_monitor

Overview:
Synthesizable multi-channel PLL lock supervisor for clk_pll_* IP instances. Per channel it:
- synchronizes the raw PLL lock signal;
- drives the PLL reset;
- qualifies lock with a stability filter;
- times out and retries failed lock attempts;
- latches loss-of-lock events.

It replaces bench-only lock checking with on-chip status and an aggregate chk_ok for the CPLD top level.

Parameters:
NUM_CH, 4, number of supervised PLL channels
SYNC_STAGES, 3, synchronizer depth on each lock input (min 2)
STABLE_CYC, 16, consecutive synchronized-high cycles required to declare lock (min 1)
TIMEOUT_CYC, 4096, max cycles in WAIT_LOCK before a retry (must be > STABLE_CYC)
RST_CYC, 8, PLL reset pulse width in cycles (min 1)
MAX_RETRY, 3, timeout retries before FAIL
CNT_W, 8, width of per-channel loss-event counter

Ports:
clkin1  in  1  reference clock for all logic; the only clock
rst  in  1  asynchronous, active-high reset
lock_in  in  NUM_CH  raw PLL lock outputs, asynchronous to clkin1
clr_i  in  1  synchronous single-cycle clear of sticky status
pll_rst_o  out  NUM_CH  reset to each PLL, active high
locked_o  out  NUM_CH  qualified lock per channel
loss_o  out  NUM_CH  sticky loss-of-lock flag
fail_o  out  NUM_CH  retries exhausted
loss_cnt_o  out  NUM_CH*CNT_W  saturating loss counters, channel i at bits [i*CNT_W +: CNT_W]
all_locked_o  out  1  AND of locked_o
chk_ok_o  out  1  all_locked_o AND no loss_o bit set

Behaviour:
Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- clkin1 is the single clock; rst is asynchronous, active high.

Reset values (while rst = 1, applied asynchronously):
- pll_rst_o = all ones.
- locked_o, loss_o, fail_o, all_locked_o, chk_ok_o = 0.
- loss_cnt_o = 0.
- Synchronizers = 0; every channel FSM = RST.
- The same holds if rst is asserted mid-operation in any state.

Synchronizer and channel FSM:
- lock_s[i] is lock_in[i] after SYNC_STAGES flops.
- Each channel runs its own FSM with states RST, WAIT_LOCK, LOCKED, FAIL.

RST:
- pll_rst_o = 1. Counts RST_CYC cycles, then goes to WAIT_LOCK.
- pll_rst_o falls on the first WAIT_LOCK cycle.

WAIT_LOCK:
- pll_rst_o = 0.
- stable counter: increments when lock_s = 1; clears to 0 when lock_s = 0.
- timeout counter: increments every cycle.
- Stable counter reaches STABLE_CYC → LOCKED; locked_o = 1 from the next cycle.
- Resulting latency: lock_in rise to locked_o rise = SYNC_STAGES+STABLE_CYC cycles, +1 for sampling uncertainty.
- Timeout counter reaches TIMEOUT_CYC with no lock:
  - retry_cnt < MAX_RETRY → retry_cnt+1, go to RST;
  - otherwise → FAIL.
- Stable completion and timeout in the same cycle → lock wins.

LOCKED:
- locked_o = 1; retry_cnt cleared on entry.
- Any single cycle with lock_s = 0 is a loss. On a loss:
  - locked_o = 0 next cycle;
  - loss_o set (sticky);
  - loss_cnt +1, saturating at 2^CNT_W-1;
  - go to RST with retry_cnt = 0. A loss restart does not consume a retry.

FAIL:
- fail_o = 1; pll_rst_o held at 1. Leaves only on clr_i.

clr_i:
- In all states: clears loss_o and loss_cnt.
- In FAIL only, also: clears fail_o, sets retry_cnt = 0, goes to RST.
- clr_i in the same cycle as a loss → loss wins: loss_o = 1, loss_cnt = 1.

Registered aggregates (one cycle after the channel flags):
- all_locked_o = &locked_o.
- chk_ok_o = all_locked_o & ~|loss_o.

Counter sizing:
- Counter widths are derived via clog2 of the parameters.
- No counter wraps: each holds at its terminal value until the state changes.

Decomposition:
- Package pll_mon_pkg holds:
  - FSM state encodings (2-bit: RST = 0, WAIT_LOCK = 1, LOCKED = 2, FAIL = 3);
  - a clog2 function;
  - parameter-legality checks.
- Sub-module pll_lock_chan holds one channel: synchronizer, FSM, counters, sticky flags.
- The top generates NUM_CH instances, concatenates loss_cnt, and registers the aggregates.

Test Plan:
1. NUM_CH=2, SYNC_STAGES=3, STABLE_CYC=16, RST_CYC=8. Release rst; raise lock_in 100 cycles after pll_rst_o falls → locked_o rises 19±1 cycles later; all_locked_o and chk_ok_o = 1 one cycle after the second channel locks.
2. In WAIT_LOCK: lock_in high for 10 cycles, low for 1, then high → stable counter restarts; locked_o rises 16+3 cycles after the re-rise, not earlier.
3. In LOCKED: 1-cycle low pulse on lock_in[0] → loss_o[0] = 1, loss_cnt[0] = 1, pll_rst_o[0] high for exactly 8 cycles; after relock, locked_o[0] = 1 but chk_ok_o stays 0 until clr_i.
4. TIMEOUT_CYC=64, MAX_RETRY=2, lock_in held 0 → exactly 3 pll_rst_o pulses, then fail_o = 1 and pll_rst_o stuck high; clr_i → fail_o = 0 and a new 8-cycle pll_rst_o pulse.
5. CNT_W=2: five lock/loss cycles → loss_cnt = 3 (saturated). clr_i coincident with a sixth loss → loss_cnt = 1, loss_o = 1.
6. Assert rst asynchronously (between clkin1 edges) while both channels are LOCKED → all outputs take reset values before the next clkin1 edge; normal lock sequence resumes after release.

Source files
------------

// File: rtl/pll_mon_pkg.sv
`default_nettype none
// ============================================================================
// pll_mon_pkg : channel state encoding, width helpers, parameter legality
// Rev 1.0
// ============================================================================
package pll_mon_pkg;

   typedef enum logic [1:0] {
      ST_RST       = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_LOCKED    = 2'd2,
      ST_FAIL      = 2'd3
   } chan_state_e;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   // Width able to hold 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      int w;
      w = clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit params_legal(input int num_ch, input int sync_stages,
                                       input int stable_cyc, input int timeout_cyc,
                                       input int rst_cyc, input int max_retry,
                                       input int cnt_w);
      return (num_ch >= 1) && (sync_stages >= 2) && (stable_cyc >= 1) &&
             (timeout_cyc > stable_cyc) && (rst_cyc >= 1) &&
             (max_retry >= 0) && (cnt_w >= 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_chan.sv
`default_nettype none
// ============================================================================
// pll_lock_chan : one supervised PLL - lock synchronizer, FSM, retry, loss stats
// Rev 1.0
// ============================================================================
module pll_lock_chan
   import pll_mon_pkg::*;
#(
   parameter int SYNC_STAGES = 3,
   parameter int STABLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 4096,
   parameter int RST_CYC     = 8,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 8
) (
   input  logic             clkin1,
   input  logic             rst,
   input  logic             lock_in,
   input  logic             clr_i,
   output logic             pll_rst_o,
   output logic             locked_o,
   output logic             loss_o,
   output logic             fail_o,
   output logic [CNT_W-1:0] loss_cnt_o
);

   localparam int RST_W    = cnt_width(RST_CYC);
   localparam int STABLE_W = cnt_width(STABLE_CYC);
   localparam int TO_W     = cnt_width(TIMEOUT_CYC);
   localparam int RETRY_W  = cnt_width(MAX_RETRY);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   lock_s;
   chan_state_e            state_q, state_d;
   logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
   logic [STABLE_W-1:0]    stable_q, stable_d;
   logic [TO_W-1:0]        to_q, to_d;
   logic [RETRY_W-1:0]     retry_q, retry_d;
   logic                   loss_q, loss_d;
   logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
   logic                   pll_rst_q, pll_rst_d;
   logic                   locked_q, locked_d;
   logic                   fail_q, fail_d;
   logic                   loss_event;

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clkin1 or posedge rst) begin
      if (rst) begin
         sync_q     <= '0;
         state_q    <= ST_RST;
         rst_cnt_q  <= '0;
         stable_q   <= '0;
         to_q       <= '0;
         retry_q    <= '0;
         loss_q     <= 1'b0;
         loss_cnt_q <= '0;
         pll_rst_q  <= 1'b1;
         locked_q   <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         stable_q   <= stable_d;
         to_q       <= to_d;
         retry_q    <= retry_d;
         loss_q     <= loss_d;
         loss_cnt_q <= loss_cnt_d;
         pll_rst_q  <= pll_rst_d;
         locked_q   <= locked_d;
         fail_q     <= fail_d;
      end
   end

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], lock_in};
      state_d    = state_q;
      rst_cnt_d  = '0;
      stable_d   = '0;
      to_d       = '0;
      retry_d    = retry_q;
      loss_d     = loss_q;
      loss_cnt_d = loss_cnt_q;
      loss_event = 1'b0;

      unique case (state_q)
         ST_RST: begin
            if (rst_cnt_q == RST_W'(RST_CYC - 1)) state_d = ST_WAIT_LOCK;
            else                                  rst_cnt_d = rst_cnt_q + 1'b1;
         end
         ST_WAIT_LOCK: begin
            // Lock completion is tested first so it wins over a coincident timeout.
            if (lock_s && (stable_q == STABLE_W'(STABLE_CYC - 1))) begin
               state_d = ST_LOCKED;
               retry_d = '0;
            end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ST_RST;
               end else begin
                  state_d = ST_FAIL;
               end
            end else begin
               stable_d = lock_s ? stable_q + 1'b1 : '0;
               to_d     = to_q + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (!lock_s) begin
               loss_event = 1'b1;
               state_d    = ST_RST;
               retry_d    = '0;
            end
         end
         ST_FAIL: begin
            if (clr_i) begin
               state_d = ST_RST;
               retry_d = '0;
            end
         end
      endcase

      // Clear first, then apply the loss so a coincident loss is never dropped.
      if (clr_i) begin
         loss_d     = 1'b0;
         loss_cnt_d = '0;
      end
      if (loss_event) begin
         loss_d = 1'b1;
         if (loss_cnt_d != {CNT_W{1'b1}}) loss_cnt_d = loss_cnt_d + 1'b1;
      end

      pll_rst_d = (state_d == ST_RST) || (state_d == ST_FAIL);
      locked_d  = (state_d == ST_LOCKED);
      fail_d    = (state_d == ST_FAIL);
   end

   assign pll_rst_o  = pll_rst_q;
   assign locked_o   = locked_q;
   assign loss_o     = loss_q;
   assign fail_o     = fail_q;
   assign loss_cnt_o = loss_cnt_q;

endmodule
`default_nettype wire

// File: rtl/pll_lock_monitor.sv
`default_nettype none
// ============================================================================
// pll_lock_monitor : NUM_CH PLL lock supervisors plus registered health summary
// Rev 1.0
// ============================================================================
module pll_lock_monitor
   import pll_mon_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 3,
   parameter int STABLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 4096,
   parameter int RST_CYC     = 8,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 8
) (
   input  logic                    clkin1,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       lock_in,
   input  logic                    clr_i,
   output logic [NUM_CH-1:0]       pll_rst_o,
   output logic [NUM_CH-1:0]       locked_o,
   output logic [NUM_CH-1:0]       loss_o,
   output logic [NUM_CH-1:0]       fail_o,
   output logic [NUM_CH*CNT_W-1:0] loss_cnt_o,
   output logic                    all_locked_o,
   output logic                    chk_ok_o
);

   if (!params_legal(NUM_CH, SYNC_STAGES, STABLE_CYC, TIMEOUT_CYC,
                     RST_CYC, MAX_RETRY, CNT_W)) begin : g_param_check
      $error("pll_lock_monitor: illegal parameter combination");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      pll_lock_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .STABLE_CYC  (STABLE_CYC),
         .TIMEOUT_CYC (TIMEOUT_CYC),
         .RST_CYC     (RST_CYC),
         .MAX_RETRY   (MAX_RETRY),
         .CNT_W       (CNT_W)
      ) u_chan (
         .clkin1     (clkin1),
         .rst        (rst),
         .lock_in    (lock_in[i]),
         .clr_i      (clr_i),
         .pll_rst_o  (pll_rst_o[i]),
         .locked_o   (locked_o[i]),
         .loss_o     (loss_o[i]),
         .fail_o     (fail_o[i]),
         .loss_cnt_o (loss_cnt_o[i*CNT_W +: CNT_W])
      );
   end

   logic all_locked_q, all_locked_d;
   logic chk_ok_q, chk_ok_d;

   always_comb begin
      all_locked_d = &locked_o;
      chk_ok_d     = (&locked_o) & ~(|loss_o);
   end

   always_ff @(posedge clkin1 or posedge rst) begin
      if (rst) begin
         all_locked_q <= 1'b0;
         chk_ok_q     <= 1'b0;
      end else begin
         all_locked_q <= all_locked_d;
         chk_ok_q     <= chk_ok_d;
      end
   end

   assign all_locked_o = all_locked_q;
   assign chk_ok_o     = chk_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_monitor.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_monitor : directed bench, two instances (long timeout / short timeout)
// Rev 1.0
// ============================================================================
module tb_pll_lock_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic       clr_a = 1'b0, clr_b = 1'b0;
   logic [1:0] lock_a = 2'b00, lock_b = 2'b00;

   logic [1:0]  pll_rst_a, locked_a, loss_a, fail_a;
   logic [15:0] cnt_a;
   logic        all_a, ok_a;
   logic [1:0]  pll_rst_b, locked_b, loss_b, fail_b;
   logic [3:0]  cnt_b;
   logic        all_b, ok_b;

   int n_checks = 0;
   int n_errors = 0;

   pll_lock_monitor #(
      .NUM_CH(2), .SYNC_STAGES(3), .STABLE_CYC(16), .TIMEOUT_CYC(4096),
      .RST_CYC(8), .MAX_RETRY(3), .CNT_W(8)
   ) u_dut_a (
      .clkin1(clk), .rst(rst_a), .lock_in(lock_a), .clr_i(clr_a),
      .pll_rst_o(pll_rst_a), .locked_o(locked_a), .loss_o(loss_a), .fail_o(fail_a),
      .loss_cnt_o(cnt_a), .all_locked_o(all_a), .chk_ok_o(ok_a)
   );

   pll_lock_monitor #(
      .NUM_CH(2), .SYNC_STAGES(3), .STABLE_CYC(16), .TIMEOUT_CYC(64),
      .RST_CYC(8), .MAX_RETRY(2), .CNT_W(2)
   ) u_dut_b (
      .clkin1(clk), .rst(rst_b), .lock_in(lock_b), .clr_i(clr_b),
      .pll_rst_o(pll_rst_b), .locked_o(locked_b), .loss_o(loss_b), .fail_o(fail_b),
      .loss_cnt_o(cnt_b), .all_locked_o(all_b), .chk_ok_o(ok_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, hi, falls, first_low;
      logic prev;
      logic [31:0] exp_cnt;

      // Reset state
      tick(3);
      check("rst_pll_rst", pll_rst_a, 2'b11);
      check("rst_locked", locked_a, 2'b00);
      check("rst_loss", loss_a, 2'b00);
      check("rst_fail", fail_a, 2'b00);
      check("rst_cnt", cnt_a, 16'h0);
      check("rst_all_ok", {all_a, ok_a}, 2'b00);

      // Test 1: release, 8-cycle PLL reset, lock latency 19
      rst_a = 1'b0;
      cyc = 0;
      while (pll_rst_a != 2'b00 && cyc < 50) begin tick(1); cyc++; end
      check("t1_rst_width", cyc, 8);
      tick(100);
      check("t1_wait_unlocked", locked_a, 2'b00);
      lock_a[0] = 1'b1;
      cyc = 0;
      while (!locked_a[0] && cyc < 60) begin tick(1); cyc++; end
      check("t1_lock_latency", cyc, 19);
      check("t1_all_pending", all_a, 1'b0);

      // Test 2: glitch in WAIT_LOCK restarts the stable filter
      lock_a[1] = 1'b1;
      tick(10);
      check("t2_no_early_lock", locked_a[1], 1'b0);
      lock_a[1] = 1'b0;
      tick(1);
      lock_a[1] = 1'b1;
      cyc = 0;
      while (!locked_a[1] && cyc < 60) begin tick(1); cyc++; end
      check("t2_relatch_latency", cyc, 19);
      check("t2_all_lag", all_a, 1'b0);
      tick(1);
      check("t1_all_locked", all_a, 1'b1);
      check("t1_chk_ok", ok_a, 1'b1);

      // Test 3: single-cycle loss in LOCKED
      lock_a[0] = 1'b0;
      tick(1);
      lock_a[0] = 1'b1;
      cyc = 0;
      while (!pll_rst_a[0] && cyc < 10) begin tick(1); cyc++; end
      check("t3_loss_detect", cyc, 3);
      check("t3_locked_drop", locked_a[0], 1'b0);
      check("t3_loss_flag", loss_a[0], 1'b1);
      check("t3_loss_cnt", cnt_a[7:0], 8'd1);
      hi = 0;
      while (pll_rst_a[0] && hi < 20) begin hi++; tick(1); end
      check("t3_rst_width", hi, 8);
      cyc = 0;
      while (!locked_a[0] && cyc < 40) begin tick(1); cyc++; end
      check("t3_relock", cyc, 16);
      tick(1);
      check("t3_all_locked", all_a, 1'b1);
      check("t3_chk_ok_held", ok_a, 1'b0);
      clr_a = 1'b1;
      tick(1);
      clr_a = 1'b0;
      check("t3_clr_loss", loss_a, 2'b00);
      check("t3_clr_cnt", cnt_a, 16'h0);
      tick(1);
      check("t3_chk_ok_after_clr", ok_a, 1'b1);

      // Test 4: short timeout, no lock -> three pulses then FAIL
      rst_b = 1'b0;
      prev = pll_rst_b[0];
      falls = 0;
      first_low = 0;
      for (int i = 0; i < 400; i++) begin
         tick(1);
         if (prev && !pll_rst_b[0]) falls++;
         if (!pll_rst_b[0] && falls == 1) first_low++;
         prev = pll_rst_b[0];
      end
      check("t4_pulses", falls, 3);
      check("t4_timeout_len", first_low, 64);
      check("t4_fail", fail_b, 2'b11);
      check("t4_pll_rst_stuck", pll_rst_b, 2'b11);
      clr_b = 1'b1;
      tick(1);
      clr_b = 1'b0;
      check("t4_fail_clr", fail_b[0], 1'b0);
      hi = 0;
      while (pll_rst_b[0] && hi < 20) begin hi++; tick(1); end
      check("t4_new_pulse", hi, 8);

      // Test 5: saturating 2-bit loss counter
      lock_b[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc = 0;
         while (!locked_b[0] && cyc < 60) begin tick(1); cyc++; end
         check("t5_lock", locked_b[0], 1'b1);
         lock_b[0] = 1'b0;
         tick(1);
         lock_b[0] = 1'b1;
         tick(3);
         exp_cnt = (k + 1 > 3) ? 32'd3 : 32'(k + 1);
         check("t5_loss_cnt", cnt_b[1:0], exp_cnt);
      end
      cyc = 0;
      while (!locked_b[0] && cyc < 60) begin tick(1); cyc++; end
      lock_b[0] = 1'b0;
      tick(1);
      lock_b[0] = 1'b1;
      tick(2);
      clr_b = 1'b1;
      tick(1);
      clr_b = 1'b0;
      check("t5_clr_vs_loss_flag", loss_b[0], 1'b1);
      check("t5_clr_vs_loss_cnt", cnt_b[1:0], 2'd1);

      // Test 6: asynchronous reset mid-operation
      check("t6_pre_ok", ok_a, 1'b1);
      tick(1);
      #3;
      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      check("t6_async_pll_rst", pll_rst_a, 2'b11);
      check("t6_async_locked", locked_a, 2'b00);
      check("t6_async_all_ok", {all_a, ok_a}, 2'b00);
      check("t6_async_b_loss", loss_b, 2'b00);
      check("t6_async_b_cnt", cnt_b, 4'h0);
      check("t6_async_b_fail", fail_b, 2'b00);
      tick(2);
      rst_a = 1'b0;
      rst_b = 1'b0;
      cyc = 0;
      while (pll_rst_a != 2'b00 && cyc < 50) begin tick(1); cyc++; end
      check("t6_rst_width", cyc, 8);
      cyc = 0;
      while (locked_a != 2'b11 && cyc < 40) begin tick(1); cyc++; end
      check("t6_relock", cyc, 16);
      tick(1);
      check("t6_chk_ok", {all_a, ok_a}, 2'b11);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
